// File: rtl/vc_plane_scheduler_pkg.sv
// Shared definitions for the VC plane scheduler and later output-port arbiters:
// FSM state encoding, selector-width helper and default timing constants.
package noc_vc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        DWELL  = 2'd2
    } sched_state_e;

    localparam int DEFAULT_QUANTUM  = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

    // A selector never shrinks below one bit, even for a single plane.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vc_plane_scheduler_rr.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping,
// with ptr itself searched last. Indices >= NUM_VC never appear.
module rr_next_vc
    import noc_vc_pkg::*;
#(
    parameter int NUM_VC    = 4,
    parameter int SEL_WIDTH = sel_width(NUM_VC)
) (
    input  logic [NUM_VC-1:0]    req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] next_idx,
    output logic                 valid
);

    logic [SEL_WIDTH-1:0] idx_s;

    // Scan NUM_VC candidates starting at ptr+1; the modulo keeps every index in range.
    always_comb begin
        next_idx = {SEL_WIDTH{1'b0}};
        valid    = 1'b0;
        idx_s    = {SEL_WIDTH{1'b0}};
        for (int i = 1; i <= NUM_VC; i++) begin
            idx_s = SEL_WIDTH'((int'(ptr) + i) % NUM_VC);
            if (!valid && req[idx_s]) begin
                valid    = 1'b1;
                next_idx = idx_s;
            end else begin
                valid    = valid;
            end
        end
    end

endmodule

// File: rtl/vc_plane_scheduler.sv
// Drives the shared VC plane selector: round-robin grants with a fixed quantum,
// bounded hold extension and a one-cycle guard slot on every plane change.
// Define VC_WEIGHT_EN to add per-plane quantum weights (vcWeight input).
module vc_plane_scheduler
    import noc_vc_pkg::*;
#(
    parameter int NUM_VC    = 4,
    parameter int SEL_WIDTH = sel_width(NUM_VC),
    parameter int QUANTUM   = DEFAULT_QUANTUM,
    parameter int CNT_WIDTH = 4,
    parameter int MAX_HOLD  = DEFAULT_MAX_HOLD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_VC-1:0]           vcPending,
    input  logic [NUM_VC-1:0]           vcHold,
`ifdef VC_WEIGHT_EN
    input  logic [NUM_VC*CNT_WIDTH-1:0] vcWeight,
`endif
    output logic [SEL_WIDTH-1:0]        VCPlaneSelector,
    output logic                        planeActive,
    output logic                        planeSwitch,
    output logic                        holdExpired
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LIMIT = CNT_WIDTH'(MAX_HOLD);
    localparam logic [CNT_WIDTH-1:0] BASE_Q_M1  = CNT_WIDTH'(QUANTUM - 1);
    localparam logic [SEL_WIDTH-1:0] PTR_INIT   = SEL_WIDTH'(NUM_VC - 1);

    sched_state_e         state_r;
    logic [SEL_WIDTH-1:0] sel_r;
    logic [SEL_WIDTH-1:0] ptr_r;
    logic [CNT_WIDTH-1:0] dwell_r;
    logic [CNT_WIDTH-1:0] hold_r;
    logic                 active_r;
    logic                 switch_r;
    logic                 expired_r;

    logic [SEL_WIDTH-1:0] pick_s;
    logic                 pick_valid_s;
    logic [NUM_VC-1:0]    others_s;
    logic                 cur_pend_s;
    logic                 cur_hold_s;
    logic                 other_pend_s;
    logic                 exit_eval_s;
    logic [CNT_WIDTH-1:0] entry_m1_s;
    logic [CNT_WIDTH-1:0] reload_m1_s;

    rr_next_vc #(
        .NUM_VC   (NUM_VC),
        .SEL_WIDTH(SEL_WIDTH)
    ) u_rr (
        .req     (vcPending),
        .ptr     (ptr_r),
        .next_idx(pick_s),
        .valid   (pick_valid_s)
    );

    // Per-cycle view of the granted plane versus the rest of the router.
    always_comb begin
        others_s        = vcPending;
        others_s[sel_r] = 1'b0;
        cur_pend_s      = vcPending[sel_r];
        cur_hold_s      = vcHold[sel_r];
        other_pend_s    = |others_s;
        exit_eval_s     = (dwell_r == CNT_ZERO) || (!cur_pend_s && !cur_hold_s);
    end

`ifdef VC_WEIGHT_EN
    logic [CNT_WIDTH-1:0] weight_s;
    logic [CNT_WIDTH-1:0] reload_r;

    // A zero weight still grants one cycle so the plane cannot be starved.
    always_comb begin
        weight_s = vcWeight[sel_r*CNT_WIDTH +: CNT_WIDTH];
        if (weight_s == CNT_ZERO) begin
            entry_m1_s = CNT_ZERO;
        end else begin
            entry_m1_s = weight_s - CNT_ONE;
        end
        reload_m1_s = reload_r;
    end

    // Weight is captured in the guard cycle and reused for same-plane reloads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_r <= CNT_ZERO;
        end else if (state_r == SWITCH) begin
            reload_r <= entry_m1_s;
        end else begin
            reload_r <= reload_r;
        end
    end
`else
    assign entry_m1_s  = BASE_Q_M1;
    assign reload_m1_s = BASE_Q_M1;
`endif

    // Scheduler FSM; the selector is loaded on entry to SWITCH so downstream
    // routing state sees the new plane during the whole guard cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            sel_r     <= {SEL_WIDTH{1'b0}};
            ptr_r     <= PTR_INIT;
            dwell_r   <= CNT_ZERO;
            hold_r    <= CNT_ZERO;
            active_r  <= 1'b0;
            switch_r  <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            switch_r  <= 1'b0;
            expired_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    active_r <= 1'b0;
                    if (pick_valid_s) begin
                        state_r  <= SWITCH;
                        sel_r    <= pick_s;
                        ptr_r    <= pick_s;
                        switch_r <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                SWITCH: begin
                    state_r  <= DWELL;
                    dwell_r  <= entry_m1_s;
                    hold_r   <= CNT_ZERO;
                    active_r <= 1'b1;
                end
                DWELL: begin
                    if (!exit_eval_s) begin
                        dwell_r <= dwell_r - CNT_ONE;
                    end else if (cur_hold_s && other_pend_s) begin
                        if (hold_r < HOLD_LIMIT) begin
                            hold_r    <= hold_r + CNT_ONE;
                        end else begin
                            expired_r <= 1'b1;
                            state_r   <= SWITCH;
                            sel_r     <= pick_s;
                            ptr_r     <= pick_s;
                            switch_r  <= 1'b1;
                            active_r  <= 1'b0;
                        end
                    end else if (cur_hold_s) begin
                        hold_r   <= hold_r;
                    end else if (other_pend_s) begin
                        state_r  <= SWITCH;
                        sel_r    <= pick_s;
                        ptr_r    <= pick_s;
                        switch_r <= 1'b1;
                        active_r <= 1'b0;
                    end else if (cur_pend_s) begin
                        dwell_r  <= reload_m1_s;
                    end else begin
                        state_r  <= IDLE;
                        active_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

    assign VCPlaneSelector = sel_r;
    assign planeActive     = active_r;
    assign planeSwitch     = switch_r;
    assign holdExpired     = expired_r;

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Directed bench for vc_plane_scheduler: expected output vectors are queued as
// each step is driven and compared once the clock edge has produced the output.
module tb_vc_plane_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] vcPending;
    logic [3:0] vcHold;
    logic [1:0] VCPlaneSelector;
    logic       planeActive;
    logic       planeSwitch;
    logic       holdExpired;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [4:0] exp_q[$];

    vc_plane_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .vcPending      (vcPending),
        .vcHold         (vcHold),
        .VCPlaneSelector(VCPlaneSelector),
        .planeActive    (planeActive),
        .planeSwitch    (planeSwitch),
        .holdExpired    (holdExpired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input logic [1:0] sel, input logic act, input logic sw, input logic ex);
        exp_q.push_back({sel, act, sw, ex});
    endtask

    task automatic check(input string tag);
        logic [4:0] e;
        logic [4:0] o;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: no expected vector queued", tag);
        end else begin
            e = exp_q.pop_front();
            o = {VCPlaneSelector, planeActive, planeSwitch, holdExpired};
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed sel=%0d act=%0b sw=%0b exp=%0b, expected sel=%0d act=%0b sw=%0b exp=%0b",
                       tag, o[4:3], o[2], o[1], o[0], e[4:3], e[2], e[1], e[0]);
            end
        end
    endtask

    // Drive inputs at a falling edge, queue the expected post-edge outputs, check.
    task automatic step(input logic [3:0] pend, input logic [3:0] hold, input logic [1:0] sel,
                        input logic act, input logic sw, input logic ex, input string tag);
        vcPending = pend;
        vcHold    = hold;
        expect_out(sel, act, sw, ex);
        @(posedge clk);
        @(negedge clk);
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        expect_out(2'd0, 1'b0, 1'b0, 1'b0);
        check(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [1:0] rr_order[3];
        rr_order[0] = 2'd1;
        rr_order[1] = 2'd3;
        rr_order[2] = 2'd0;
        rst       = 1'b0;
        vcPending = 4'b0000;
        vcHold    = 4'b0000;
        @(negedge clk);
        expect_out(2'd0, 1'b0, 1'b0, 1'b0);
        check("reset_state");
        rst = 1'b1;

        // Single plane: guard cycle then continuous activity with no further switches.
        step(4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, "single_switch");
        for (int i = 0; i < 8; i++) step(4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, "single_active");
        step(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, "single_to_idle");
        step(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, "idle_hold_sel");

        // Round robin over planes 0,1,3 starting from a fresh pointer.
        do_reset("reset_before_rr");
        step(4'b1011, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, "rr_switch0");
        for (int i = 0; i < 4; i++) step(4'b1011, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "rr_active0");
        for (int p = 0; p < 3; p++) begin
            step(4'b1011, 4'b0000, rr_order[p], 1'b0, 1'b1, 1'b0, "rr_switch");
            for (int i = 0; i < 4; i++) step(4'b1011, 4'b0000, rr_order[p], 1'b1, 1'b0, 1'b0, "rr_active");
        end
        step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, "rr_to_idle");

        // Hold extension: VC0 keeps the plane for 4+8 cycles, then expiry forces VC1.
        do_reset("reset_before_hold");
        step(4'b0011, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, "hold_switch0");
        for (int i = 0; i < 12; i++) step(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, "hold_active0");
        step(4'b0011, 4'b0001, 2'd1, 1'b0, 1'b1, 1'b1, "hold_expired");

        // Early exit: VC1 drops its request at dwell=2 with nothing else pending.
        step(4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, "early_dwell3");
        step(4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, "early_dwell2");
        step(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, "early_idle");
        step(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, "early_idle_stay");

        // Async reset in the middle of a dwell, then restart from a fresh pointer.
        step(4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, "pre_reset_switch3");
        step(4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, "pre_reset_active3");
        do_reset("async_reset_mid_dwell");
        step(4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, "post_reset_switch3");
        step(4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, "post_reset_active3");

        // Hold with nobody else waiting keeps the plane without counting toward expiry.
        for (int i = 0; i < 14; i++) step(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, "solo_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
